// File: rtl/axi_rd_qos_pkg.sv
// axi_rd_qos_pkg: shared types, default constants and the round-robin picker for the AR QoS arbiter
package axi_rd_qos_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int DEF_MAX_OUT = 4;
  localparam int DEF_WINDOW = 4096;
  localparam int DEF_BEAT_BUDGET = 1024;
  // Returns the first set bit of req at or after index last, wrapping.
  // Unused upper request bits are zero, so wrapping at 16 orders the
  // same as wrapping at the real master count.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] last);
    logic [3:0] idx;
    rr_pick = last;
    for (int k = 15; k >= 0; k--) begin
      idx = last + 4'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/axi_rd_qos_cnt.sv
// axi_rd_qos_cnt: per-master outstanding-read counter, beat budget and eligibility
// Ports: clock/reset; req = master AR valid; len = its arlen; inc = grant; dec = R last for this master;
// wrap = budget window wrap; cnt = outstanding bursts; eligible; underflow = R last seen at count 0.
// Budget logic present only when AXI_RD_QOS_BUDGET_EN is defined.
module axi_rd_qos_cnt
  import axi_rd_qos_pkg::*;
#(
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int BEAT_BUDGET = DEF_BEAT_BUDGET,
  parameter int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic [7:0]       len,
  input  logic             inc,
  input  logic             dec,
  input  logic             wrap,
  output logic [CNT_W-1:0] cnt,
  output logic             eligible,
  output logic             underflow
);
  logic room;
  assign room = cnt < CNT_W'(MAX_OUT);
  assign underflow = dec & ~inc & (cnt == '0);
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (inc & ~dec) cnt <= cnt + CNT_W'(1);
    else if (dec & ~inc & (cnt != '0)) cnt <= cnt - CNT_W'(1);
`ifdef AXI_RD_QOS_BUDGET_EN
  logic [15:0] budget;
  logic [16:0] need;
  assign need = 17'(len) + 17'd1;
  assign eligible = req & room & ({1'b0, budget} >= need);
  // A reload and a grant in the same cycle charge the grant against the fresh budget.
  always_ff @(posedge clock)
    if (reset) budget <= 16'(BEAT_BUDGET);
    else budget <= (wrap ? 16'(BEAT_BUDGET) : budget) - (inc ? need[15:0] : 16'd0);
`else
  logic unused;
  assign unused = ^{len, wrap, BEAT_BUDGET[0]};
  assign eligible = req & room;
`endif
endmodule

// File: rtl/axi_rd_qos_arbiter.sv
// axi_rd_qos_arbiter: round-robin AR arbiter granting only masters under their outstanding/beat limits
// Ports: clock, reset (sync, active-high); s_ar* = packed per-master AR channels; m_ar* = registered AR to slave
// with m_arid = granted master; m_r* = R channel observation; outstanding = packed per-master counters;
// throttled = requesting but ineligible; err_underflow = sticky R-last-at-zero flag.
// Define AXI_RD_QOS_BUDGET_EN to add the per-window beat budget.
module axi_rd_qos_arbiter
  import axi_rd_qos_pkg::*;
#(
  parameter int N_MST = 4,
  parameter int ADDR_W = 32,
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int BEAT_BUDGET = DEF_BEAT_BUDGET
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_MST-1:0]                       s_arvalid,
  output logic [N_MST-1:0]                       s_arready,
  input  logic [N_MST*ADDR_W-1:0]                s_araddr,
  input  logic [N_MST*8-1:0]                     s_arlen,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  output logic [ADDR_W-1:0]                      m_araddr,
  output logic [7:0]                             m_arlen,
  output logic [$clog2(N_MST)-1:0]               m_arid,
  input  logic                                   m_rvalid,
  input  logic                                   m_rready,
  input  logic                                   m_rlast,
  input  logic [$clog2(N_MST)-1:0]               m_rid,
  output logic [N_MST*$clog2(MAX_OUT+1)-1:0]     outstanding,
  output logic [N_MST-1:0]                       throttled,
  output logic                                   err_underflow
);
  localparam int ID_W = $clog2(N_MST);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  state_t state;
  logic [ID_W-1:0] ptr, g;
  logic [N_MST-1:0] eligible, uf;
  logic load, wrap;
  logic [ADDR_W-1:0] addr_a [N_MST];
  logic [7:0] len_a [N_MST];
  assign g = ID_W'(rr_pick(16'(eligible), 4'(ptr)));
  // The output register loads when empty or when its current AR is being accepted.
  assign load = ~reset & (|eligible) & ((state == IDLE) | m_arready);
  assign s_arready = load ? {{(N_MST-1){1'b0}}, 1'b1} << g : '0;
  assign throttled = s_arvalid & ~eligible;
  assign m_arvalid = state == HOLD;
  for (genvar i = 0; i < N_MST; i++) begin : g_mst
    assign addr_a[i] = s_araddr[i*ADDR_W +: ADDR_W];
    assign len_a[i] = s_arlen[i*8 +: 8];
    axi_rd_qos_cnt #(.MAX_OUT(MAX_OUT), .BEAT_BUDGET(BEAT_BUDGET)) u_cnt (
      .clock, .reset,
      .req(s_arvalid[i]),
      .len(len_a[i]),
      .inc(s_arready[i]),
      .dec(m_rvalid & m_rready & m_rlast & (m_rid == ID_W'(i))),
      .wrap,
      .cnt(outstanding[i*CNT_W +: CNT_W]),
      .eligible(eligible[i]),
      .underflow(uf[i])
    );
  end
`ifdef AXI_RD_QOS_BUDGET_EN
  logic [$clog2(WINDOW)-1:0] win;
  assign wrap = win == ($clog2(WINDOW))'(WINDOW - 1);
  always_ff @(posedge clock)
    if (reset) win <= '0;
    else win <= wrap ? '0 : win + ($clog2(WINDOW))'(1);
`else
  logic unused_win;
  assign unused_win = WINDOW[0];
  assign wrap = 1'b0;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      m_araddr <= '0;
      m_arlen <= '0;
      m_arid <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= load ? HOLD : m_arready ? IDLE : state;
      err_underflow <= err_underflow | (|uf);
      if (load) begin
        ptr <= (g == ID_W'(N_MST - 1)) ? '0 : g + ID_W'(1);
        m_araddr <= addr_a[g];
        m_arlen <= len_a[g];
        m_arid <= g;
      end
    end
endmodule

// File: doc/axi_rd_qos_arbiter.md
# axi_rd_qos_arbiter

Read-address arbiter and rate regulator placed between the four AXI masters (victim plus three attackers) and the shared slave port in `design_1`. It grants AR requests round-robin, but only to eligible masters. A master is eligible while it is below a per-master outstanding-read limit and, optionally, within a per-window beat budget. This bounds the latency a single-beat victim read can suffer under a 256-beat outstanding read flood.

## Interface
Parameters:
- `N_MST`, default 4: number of requesting masters; master 0 is the victim port.
- `ADDR_W`, default 32: AR address width.
- `MAX_OUT`, default 4: maximum outstanding read bursts per master.
- `WINDOW`, default 4096: budget window length in clock cycles.
- `BEAT_BUDGET`, default 1024: beats granted per master per window, 16-bit.

Ports:
- `clock`, in, 1: single clock, 100 MHz.
- `reset`, in, 1: synchronous, active-high.
- `s_arvalid`, in, N_MST: per-master AR valid.
- `s_arready`, out, N_MST: per-master AR ready.
- `s_araddr`, in, N_MST*ADDR_W: packed addresses; master i occupies slice i.
- `s_arlen`, in, N_MST*8: packed burst lengths.
- `m_arvalid`, out, 1: AR valid to the slave.
- `m_arready`, in, 1: AR ready from the slave.
- `m_araddr`, out, ADDR_W: forwarded address.
- `m_arlen`, out, 8: forwarded burst length.
- `m_arid`, out, ID_W: index of the granted master; ID_W = clog2(N_MST).
- `m_rvalid`, `m_rready`, `m_rlast`, in, 1 each: R channel observation only.
- `m_rid`, in, ID_W: ID of the observed R beat.
- `outstanding`, out, N_MST*CNT_W: per-master counters; CNT_W = clog2(MAX_OUT+1).
- `throttled`, out, N_MST: master is requesting but ineligible this cycle.
- `err_underflow`, out, 1: sticky flag set when an R last arrives for a master whose counter is 0.

## Operation
- FSM states:
  - IDLE to HOLD when at least one eligible master is requesting.
  - HOLD to IDLE on `m_arready` when no eligible request is present.
  - HOLD to HOLD (reload) on `m_arready` when an eligible request is present.
- Eligibility for master i: `s_arvalid[i]`, `outstanding[i] < MAX_OUT`, and (budget feature only) `budget[i] >= arlen+1`.
- Round-robin:
  - Search starts at the index after the last grant and wraps from N_MST-1 to 0.
  - After reset, master 0 has top priority.
- Grant, i.e. loading the output register:
  - `s_arready[g]` is asserted for exactly that cycle.
  - addr, len and id are registered.
  - `outstanding[g]` increments.
- Decrement: on `m_rvalid & m_rready & m_rlast`, `outstanding[m_rid]` decrements.
- Grant and R last for the same master in the same cycle leave the count unchanged.
- Decrement at 0: the count stays 0 and `err_underflow` is set. Only reset clears it.
- `throttled[i] = s_arvalid[i] & ~eligible[i]`, combinational.
- `s_arready` is never asserted to an ineligible master, and never to more than one master.

## Timing
- Reset values:
  - `m_arvalid`, `s_arready`, `throttled`, `err_underflow`: 0.
  - `m_araddr`, `m_arlen`, `m_arid`: 0.
  - All counters: 0.
  - Round-robin pointer: 0.
  - Budgets: BEAT_BUDGET.
  - Window counter: 0.
- Latency: `s_arvalid` rising at cycle t with the arbiter idle gives `m_arvalid` at t+1.
- Throughput: one AR per cycle through the HOLD reload path.
- `m_araddr`, `m_arlen` and `m_arid` are stable while `m_arvalid & ~m_arready`.
- Eligibility uses register state from the start of the cycle. An R last in cycle t affects eligibility from t+1.
- Reset mid-burst: all state clears. In-flight R beats arriving afterwards trigger `err_underflow`, which is accepted behaviour; the bench must reset the slave together with this block.

## Configuration
- `AXI_RD_QOS_BUDGET_EN` defined:
  - The window counter counts 0..WINDOW-1 and wraps.
  - At wrap, every budget reloads to BEAT_BUDGET.
  - A grant subtracts arlen+1 from the granted master's budget.
  - Reload and grant in the same cycle: budget = BEAT_BUDGET-(arlen+1).
- Macro undefined:
  - No budget or window logic.
  - Eligibility depends on the outstanding count only.
  - The parameters are accepted but ignored.

## Structure
- Package `axi_rd_qos_pkg`:
  - FSM state enum (IDLE, HOLD).
  - Default constants for MAX_OUT, WINDOW and BEAT_BUDGET.
  - Function `rr_pick(req, last)` returning the next index.
- Sub-module `axi_rd_qos_cnt`:
  - One instance per master.
  - Contains the outstanding counter, the budget register and the eligibility compare.

## Test plan
- Reset, then master 0 alone issues a 1-beat read at 0x4000_0000 -> `m_arvalid` one cycle later with `m_arid`=0, `outstanding[0]`=1. R last returns it to 0.
- Master 1 holds 4 outstanding 256-beat bursts with no R returns -> `throttled[1]`=1 and `s_arready[1]` stays 0. Master 0 is still granted within 2 cycles.
- Masters 0..3 request continuously with `m_arready`=1 -> grant order 0,1,2,3,0 with no master skipped.
- Grant to master 2 and R last with `m_rid`=2 in the same cycle -> `outstanding[2]` unchanged.
- R last with `m_rid`=3 while `outstanding[3]`=0 -> count stays 0 and `err_underflow`=1 until reset.
- With `AXI_RD_QOS_BUDGET_EN`, BEAT_BUDGET=512, WINDOW=4096: master 1 gets two 256-beat grants, then is throttled until the window wraps and is then granted again.
